mips_mc_control: RTL and testbench



---
 rtl/mips_pkg.sv | 45 ++++
 rtl/mips_mc_control_if.sv | 10 +
 rtl/mips_mem_watchdog.sv | 36 +++
 rtl/mips_mc_control.sv | 180 ++++++++++++++++++
 tb/tb_mips_mc_control.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU operation selects, mux selects and the controller state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;

  localparam logic [5:0] ALU_ADD   = 6'b100000;
  localparam logic [5:0] ALU_SUB   = 6'b100011;
  localparam logic [5:0] ALU_RTYPE = 6'b000000;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_MEM = 4'd7,
    S_WB_I   = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Unified memory port handshake between the controller (master) and memory.
interface mips_mc_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mips_mem_watchdog.sv
// Counts consecutive stalled memory cycles; flags a timeout on the cycle the
// count would reach MEM_TIMEOUT and latches a sticky mem_err.
module mips_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req,
  input  logic mem_ready,
  output logic timeout,
  output logic mem_err
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_stall_cnt;
  logic          r_mem_err;
  logic          w_stall;

  assign w_stall = mem_req & ~mem_ready;
  assign timeout = w_stall && (r_stall_cnt == CW'(MEM_TIMEOUT - 1));
  assign mem_err = r_mem_err;

  // Counter is per request: any cycle without a stalled request restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      else         r_stall_cnt <= '0;
      if (timeout) r_mem_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main controller. Optional performance counters are
// enabled with the MIPS_MC_PERF_CNT_EN macro.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter state_t      RESET_STATE = S_FETCH,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  mips_mc_control_if.master mem,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [5:0]        alu_op,
  output logic [5:0]        alu_funct,
  output logic              reg_we,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              illegal,
  output logic              mem_err
`ifdef MIPS_MC_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  state_t r_state, w_next_fsm, w_next;
  logic   r_illegal;
  logic   w_mem_req, w_mem_we, w_iord, w_timeout;

  mips_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_req  (w_mem_req),
    .mem_ready(mem.mem_ready),
    .timeout  (w_timeout),
    .mem_err  (mem_err)
  );

  assign mem.mem_req = w_mem_req;
  assign mem.mem_we  = w_mem_we;
  assign mem.iord    = w_iord;
  assign illegal     = r_illegal;

  // Outputs are gated by rst_n so the memory request drops the instant reset asserts.
  always_comb begin
    w_next_fsm = r_state;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_iord     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    alu_funct  = '0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          w_mem_req = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem.mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            w_next_fsm = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          case (opcode)
            OP_RTYPE:              w_next_fsm = S_EXEC_R;
            OP_LW, OP_SW, OP_ADDI: w_next_fsm = S_ADDR;
            OP_BEQ:                w_next_fsm = S_BRANCH;
            OP_J:                  w_next_fsm = S_JUMP;
            default:               w_next_fsm = S_TRAP;
          endcase
        end
        S_EXEC_R: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_RTYPE;
          alu_funct  = funct;
          w_next_fsm = S_WB_R;
        end
        S_WB_R: begin
          reg_we     = 1'b1;
          reg_dst    = 1'b1;
          w_next_fsm = S_FETCH;
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          case (opcode)
            OP_LW:   w_next_fsm = S_MEM_RD;
            OP_SW:   w_next_fsm = S_MEM_WR;
            OP_ADDI: w_next_fsm = S_WB_I;
            default: w_next_fsm = S_TRAP;
          endcase
        end
        S_MEM_RD: begin
          w_mem_req = 1'b1;
          w_iord    = 1'b1;
          if (mem.mem_ready) w_next_fsm = S_WB_MEM;
        end
        S_MEM_WR: begin
          w_mem_req = 1'b1;
          w_mem_we  = 1'b1;
          w_iord    = 1'b1;
          if (mem.mem_ready) w_next_fsm = S_FETCH;
        end
        S_WB_MEM: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
          w_next_fsm = S_FETCH;
        end
        S_WB_I: begin
          reg_we     = 1'b1;
          w_next_fsm = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_we      = zero;
          pc_src     = PCSRC_ALUOUT;
          w_next_fsm = S_FETCH;
        end
        S_JUMP: begin
          pc_we      = 1'b1;
          pc_src     = PCSRC_JUMP;
          w_next_fsm = S_FETCH;
        end
        default: w_next_fsm = S_TRAP;
      endcase
    end
  end

  // Timeout override lives outside the main decode to keep the watchdog path acyclic.
  always_comb begin
    w_next = w_next_fsm;
    if (w_timeout) w_next = S_TRAP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RESET_STATE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_next_fsm == S_TRAP) r_illegal <= 1'b1;
    end
  end

`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt, r_instr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (r_state != S_FETCH && w_next == S_FETCH) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed self-checking bench for mips_mc_control.
module tb_mips_mc_control;
  import mips_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       ir_we, pc_we, alu_src_a, reg_we, reg_dst, mem_to_reg, illegal, mem_err;
  logic [1:0] pc_src, alu_src_b;
  logic [5:0] alu_op, alu_funct;
`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mips_mc_control_if mem_if ();

  mips_mc_control #(.MEM_TIMEOUT(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem       (mem_if.master),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .alu_funct (alu_funct),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .illegal   (illegal),
    .mem_err   (mem_err)
`ifdef MIPS_MC_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'b000000;
    funct = 6'b100000;
    zero = 1'b0;
    mem_if.mem_ready = 1'b1;
    #12;
    chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_ir_we", 32'(ir_we), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'h20);
    chk("rst_alu_funct", 32'(alu_funct), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    rst_n = 1'b1;
    #1;

    // add: cycles FETCH, DECODE, EXEC_R, WB_R
    chk("add_f_req", 32'(mem_if.mem_req), 32'd1);
    chk("add_f_iord", 32'(mem_if.iord), 32'd0);
    chk("add_f_irwe", 32'(ir_we), 32'd1);
    chk("add_f_pcwe", 32'(pc_we), 32'd1);
    chk("add_f_srcb", 32'(alu_src_b), 32'd1);
    cyc();
    chk("add_d_srcb", 32'(alu_src_b), 32'd3);
    chk("add_d_srca", 32'(alu_src_a), 32'd0);
    chk("add_d_req", 32'(mem_if.mem_req), 32'd0);
    cyc();
    chk("add_e_op", 32'(alu_op), 32'd0);
    chk("add_e_funct", 32'(alu_funct), 32'h20);
    chk("add_e_srca", 32'(alu_src_a), 32'd1);
    cyc();
    chk("add_wb_regwe", 32'(reg_we), 32'd1);
    chk("add_wb_regdst", 32'(reg_dst), 32'd1);
    cyc();

    // lw with three stall cycles in MEM_RD
    opcode = 6'b100011;
    #1;
    chk("lw_f_irwe", 32'(ir_we), 32'd1);
    cyc();
    cyc();
    chk("lw_a_srcb", 32'(alu_src_b), 32'd2);
    chk("lw_a_srca", 32'(alu_src_a), 32'd1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      mem_if.mem_ready = 1'b0;
      #1;
      chk("lw_stall_req", 32'(mem_if.mem_req), 32'd1);
      chk("lw_stall_iord", 32'(mem_if.iord), 32'd1);
      chk("lw_stall_regwe", 32'(reg_we), 32'd0);
      cyc();
    end
    mem_if.mem_ready = 1'b1;
    #1;
    chk("lw_rdy_req", 32'(mem_if.mem_req), 32'd1);
    cyc();
    chk("lw_wb_regwe", 32'(reg_we), 32'd1);
    chk("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
    chk("lw_wb_regdst", 32'(reg_dst), 32'd0);
    chk("lw_wb_memerr", 32'(mem_err), 32'd0);
    cyc();

    // sw
    opcode = 6'b101011;
    cyc();
    cyc();
    cyc();
    chk("sw_m_we", 32'(mem_if.mem_we), 32'd1);
    chk("sw_m_req", 32'(mem_if.mem_req), 32'd1);
    chk("sw_m_iord", 32'(mem_if.iord), 32'd1);
    cyc();
    chk("sw_back_fetch_we", 32'(mem_if.mem_we), 32'd0);
    chk("sw_back_fetch_iord", 32'(mem_if.iord), 32'd0);
    chk("sw_back_fetch_irwe", 32'(ir_we), 32'd1);

    // addi
    opcode = 6'b001000;
    cyc();
    cyc();
    cyc();
    chk("addi_wb_regwe", 32'(reg_we), 32'd1);
    chk("addi_wb_m2r", 32'(mem_to_reg), 32'd0);
    chk("addi_wb_regdst", 32'(reg_dst), 32'd0);
    cyc();

    // beq taken then not taken
    opcode = 6'b000100;
    zero = 1'b1;
    cyc();
    cyc();
    chk("beq1_pcwe", 32'(pc_we), 32'd1);
    chk("beq1_pcsrc", 32'(pc_src), 32'd1);
    chk("beq1_aluop", 32'(alu_op), 32'h23);
    cyc();
    chk("beq1_fetch", 32'(ir_we), 32'd1);
    zero = 1'b0;
    cyc();
    cyc();
    chk("beq0_pcwe", 32'(pc_we), 32'd0);
    chk("beq0_aluop", 32'(alu_op), 32'h23);
    cyc();
    chk("beq0_fetch_req", 32'(mem_if.mem_req), 32'd1);
    chk("beq0_fetch_iord", 32'(mem_if.iord), 32'd0);

    // j
    opcode = 6'b000010;
    cyc();
    cyc();
    chk("j_pcwe", 32'(pc_we), 32'd1);
    chk("j_pcsrc", 32'(pc_src), 32'd2);
    cyc();

    // fetch stall timeout after 255 stalled cycles
    mem_if.mem_ready = 1'b0;
    repeat (254) cyc();
    chk("to_before_err", 32'(mem_err), 32'd0);
    chk("to_before_req", 32'(mem_if.mem_req), 32'd1);
    cyc();
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_trap_req", 32'(mem_if.mem_req), 32'd0);
    chk("to_illegal", 32'(illegal), 32'd0);
    mem_if.mem_ready = 1'b1;
    cyc();
    chk("to_trap_hold", 32'(mem_if.mem_req), 32'd0);
    chk("to_err_sticky", 32'(mem_err), 32'd1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk("to_rst_err", 32'(mem_err), 32'd0);
    chk("to_rst_req", 32'(mem_if.mem_req), 32'd1);

    // unsupported opcode
    opcode = 6'b111111;
    cyc();
    chk("ill_dec", 32'(illegal), 32'd0);
    cyc();
    chk("ill_set", 32'(illegal), 32'd1);
    chk("ill_req", 32'(mem_if.mem_req), 32'd0);
    repeat (3) cyc();
    chk("ill_hold_req", 32'(mem_if.mem_req), 32'd0);
    chk("ill_hold_irwe", 32'(ir_we), 32'd0);
    chk("ill_sticky", 32'(illegal), 32'd1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk("ill_rst_clr", 32'(illegal), 32'd0);
    chk("ill_rst_req", 32'(mem_if.mem_req), 32'd1);

    // reset while a store is stalled in MEM_WR
    opcode = 6'b101011;
    cyc();
    cyc();
    mem_if.mem_ready = 1'b0;
    cyc();
    chk("mwr_we", 32'(mem_if.mem_we), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mwr_rst_req", 32'(mem_if.mem_req), 32'd0);
    chk("mwr_rst_we", 32'(mem_if.mem_we), 32'd0);
    chk("mwr_rst_regwe", 32'(reg_we), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mwr_post_req", 32'(mem_if.mem_req), 32'd1);
    chk("mwr_post_iord", 32'(mem_if.iord), 32'd0);
    chk("mwr_post_we", 32'(mem_if.mem_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
